// File: rtl/fetch_pkg.sv
// Types shared across the fetch/decode boundary: the fetch packet and its default width.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_4;
  } fetch_packet_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling queue with single-cycle flush.
// Define INSTR_QUEUE_BYPASS_EN to let an empty queue forward the incoming packet combinationally.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            instr_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            pc_4_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic [XLEN-1:0]            instr_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            pc_4_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_packet_t      mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  fetch_packet_t      pkt_in;
  fetch_packet_t      head;
  logic               bypass;
  logic               push;
  logic               pop;

  assign head      = mem_q[rptr_q];
  assign count     = count_q;
  assign ready_out = (count_q != CNT_W'(DEPTH));

  always_comb begin
    pkt_in = '{instr: instr_in, pc: pc_in, pc_4: pc_4_in};
    bypass = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    bypass = (count_q == '0) && valid_in && !flush;
`endif
    // A bypassed packet that decode takes right away never touches storage.
    push      = valid_in && ready_out && !flush && !(bypass && ready_in);
    pop       = (count_q != '0) && ready_in && !flush;
    valid_out = !flush && ((count_q != '0) || bypass);
    if (bypass) begin
      instr_out = pkt_in.instr;
      pc_out    = pkt_in.pc;
      pc_4_out  = pkt_in.pc_4;
    end else begin
      instr_out = head.instr;
      pc_out    = head.pc;
      pc_4_out  = head.pc_4;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is reset so the head fields never show X to decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= pkt_in;
    end
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Decoupling queue at the fetch→decode boundary. It is the receiving end of the fetch stage's valid/ready handshake: it captures `{instr, pc, pc+4}` packets when fetch asserts valid, and asserts `ready_out` back to fetch while space remains. It presents packets to decode in order over a second valid/ready handshake. It holds up to `DEPTH` packets, so short decode stalls do not stall fetch, and it supports a single-cycle flush for redirects.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `XLEN`, 32: instruction and PC width.
---
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Asserting it (0) clears all state immediately.
- `instr_in`, input, XLEN: instruction from fetch.
- `pc_in`, input, XLEN: PC of `instr_in`.
- `pc_4_in`, input, XLEN: PC+4 from fetch.
- `valid_in`, input, 1: fetch packet valid.
- `ready_out`, output, 1: queue can accept a packet this cycle (to fetch).
- `instr_out`, output, XLEN: head instruction (to decode).
- `pc_out`, output, XLEN: head PC.
- `pc_4_out`, output, XLEN: head PC+4.
- `valid_out`, output, 1: head packet valid.
- `ready_in`, input, 1: decode accepts the head this cycle.
- `flush`, input, 1: discard all queued packets (redirect/mispredict).
- `count`, output, $clog2(DEPTH)+1: current occupancy.

## Operation
- **Push** occurs when `valid_in && ready_out && !flush`. The packet is written at the write pointer and `wptr` increments.
- **Pop** occurs when `valid_out && ready_in && !flush`. The read pointer `rptr` increments.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately: +1 on push only, −1 on pop only, unchanged on both or neither.
- `ready_out = (count != DEPTH)`, combinational from registered state only. When full, fetch is not accepted, even if decode pops in the same cycle.
- `valid_out = (count != 0)`, except when `INSTR_QUEUE_BYPASS_EN` applies (see Configuration).
- Output fields come from `mem[rptr]`. Their value is don't-care when `valid_out=0`, but they must not be X after reset: storage resets to 0.
- **Flush** has priority over push and pop. On the next edge, `count`, `wptr` and `rptr` become 0. A packet offered in the flush cycle is dropped. While `flush=1`, `valid_out` is forced to 0.
- **Reset:** `count=0`, pointers 0, `ready_out=1`, `valid_out=0`, all data outputs 0.
- Packets leave in arrival order. No duplication and no loss except on flush.

## Timing
- Without bypass, latency is 1 cycle: a packet pushed at edge N is visible with `valid_out=1` after edge N.
- Throughput is 1 packet/cycle in steady state when `0 < count < DEPTH`.
- Empty queue with a push only: `count` goes to 1 and `valid_out` rises the next cycle.
- Full queue with a pop only: `ready_out` rises the next cycle.
- Reset asserted mid-operation clears state asynchronously, with no wait for a clock edge. Deassertion is synchronous to `clk` via the standard reset synchroniser upstream.
- `valid_out` and the data outputs depend only on registered state, except under bypass.

## Configuration
- `INSTR_QUEUE_BYPASS_EN` defined:
  - When `count==0 && valid_in && !flush`, the input packet drives the outputs combinationally and `valid_out=1`.
  - If `ready_in` is also 1, the packet is consumed directly and not written.
  - Otherwise it is written normally.
  - Latency is 0 when empty.
- Undefined: no combinational path from fetch inputs to decode outputs; latency is always 1 cycle.

## Structure
- Shared package `fetch_pkg` holds:
  - `fetch_packet_t`, a packed struct `{instr, pc, pc_4}` of XLEN each.
  - `XLEN_DEFAULT = 32`.
- Storage is an array of `fetch_packet_t` with inline pointer and count logic. No sub-module is needed; a generic FIFO would obscure the flush priority and the bypass path.

## Test plan
1. **Reset:** hold `reset=0` for 3 cycles, then release → `ready_out=1`, `valid_out=0`, `count=0`, outputs 0.
2. **Fill to full, then drain:** push pc 0x0, 0x4, 0x8, 0xC with `ready_in=0` → `count=4`, `ready_out=0`. Then set `ready_in=1` → pops in order 0x0, 0x4, 0x8, 0xC, each with `pc_4_out=pc+4`.
3. **Full with simultaneous offer and pop:** `count=4`, `valid_in=1` (pc 0x10), `ready_in=1` → pc 0x0 popped, 0x10 not accepted, `count=3`. Next cycle 0x10 is accepted.
4. **Wrap-around:** 10 continuous push/pop cycles with pcs 0x100..0x124 → output order exactly matches input and `count` stays constant.
5. **Flush with push and pop asserted:** `count=2`, `flush=1` with `valid_in=1` (pc 0x200) and `ready_in=1` → `valid_out=0` that cycle. Next cycle `count=0`, and 0x200 never appears.
6. **Bypass:** empty queue, `valid_in=1`, pc 0x300, `ready_in=1` → with `INSTR_QUEUE_BYPASS_EN`, `pc_out=0x300` and `valid_out=1` in the same cycle, `count` stays 0. Without the macro, it appears one cycle later.
